// File: rtl/text_console.sv
// Character-stream front end for the 70x30 text display: accepts ASCII bytes,
// tracks the cursor, writes glyphs into the character RAM and scrolls by rotating the top-row base.
module text_console #(
   parameter int COLS = 70,
   parameter int ROWS = 30
) (
   input  logic        CLOCK_50,
   input  logic        clrn,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   output logic [11:0] wraddress,
   output logic [7:0]  wrdata,
   output logic        wren,
   output logic [4:0]  scroll_base,
   output logic [11:0] cursor_addr
);

   localparam int         CELLS    = COLS * ROWS;
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, PUT, CLR_ROW, CLR_ALL} state_t;

   state_t      state_q, state_d;
   logic [6:0]  cx_q, cx_d;
   logic [4:0]  ly_q, ly_d;
   logic [4:0]  base_q, base_d;
   logic [11:0] cnt_q, cnt_d;
   logic [11:0] row_addr_q, row_addr_d;
   logic        pend_q, pend_d;
   logic        wren_q, wren_d;
   logic [11:0] waddr_q, waddr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [11:0] cur_q, cur_d;

   logic [4:0]  pr;
   logic [4:0]  base_inc;

   // Physical row = (base + logical row) mod ROWS, done with a compare-subtract.
   function automatic logic [4:0] wrap_row(input logic [4:0] b, input logic [4:0] l);
      logic [5:0] s;
      s = {1'b0, b} + {1'b0, l};
      if (s >= 6'(ROWS)) s = s - 6'(ROWS);
      return s[4:0];
   endfunction

   function automatic logic [11:0] row_start(input logic [4:0] r);
      return 12'(r) * 12'(COLS);
   endfunction

   assign pr       = wrap_row(base_q, ly_q);
   assign base_inc = (base_q == LAST_ROW) ? 5'd0 : base_q + 5'd1;

   always_comb begin
      state_d    = state_q;
      cx_d       = cx_q;
      ly_d       = ly_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      row_addr_d = row_addr_q;
      pend_d     = pend_q;
      wren_d     = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;

      case (state_q)
         IDLE: begin
            if (char_valid) begin
               if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                  state_d = PUT;
                  wren_d  = 1'b1;
                  waddr_d = row_start(pr) + 12'(cx_q);
                  wdata_d = char_data;
                  if (cx_q != LAST_COL) begin
                     cx_d = cx_q + 7'd1;
                  end else begin
                     cx_d = 7'd0;
                     if (ly_q != LAST_ROW) begin
                        ly_d = ly_q + 5'd1;
                     end else begin
                        // Row to blank after the glyph write is the old top row.
                        base_d     = base_inc;
                        row_addr_d = row_start(base_q);
                        pend_d     = 1'b1;
                     end
                  end
               end else if (char_data == 8'h0A) begin
                  cx_d = 7'd0;
                  if (ly_q != LAST_ROW) begin
                     ly_d = ly_q + 5'd1;
                  end else begin
                     base_d     = base_inc;
                     row_addr_d = row_start(base_q);
                     state_d    = CLR_ROW;
                     wren_d     = 1'b1;
                     waddr_d    = row_start(base_q);
                     wdata_d    = 8'h00;
                     cnt_d      = 12'd1;
                  end
               end else if (char_data == 8'h0D) begin
                  cx_d = 7'd0;
               end else if (char_data == 8'h08) begin
                  if (cx_q != 7'd0) begin
                     cx_d    = cx_q - 7'd1;
                     state_d = PUT;
                     wren_d  = 1'b1;
                     waddr_d = row_start(pr) + 12'(cx_q - 7'd1);
                     wdata_d = 8'h00;
                  end else if (ly_q != 5'd0) begin
                     ly_d    = ly_q - 5'd1;
                     cx_d    = LAST_COL;
                     state_d = PUT;
                     wren_d  = 1'b1;
                     waddr_d = row_start(wrap_row(base_q, ly_q - 5'd1)) + 12'(LAST_COL);
                     wdata_d = 8'h00;
                  end
               end else if (char_data == 8'h0C) begin
                  cx_d    = 7'd0;
                  ly_d    = 5'd0;
                  base_d  = 5'd0;
                  state_d = CLR_ALL;
                  wren_d  = 1'b1;
                  waddr_d = 12'd0;
                  wdata_d = 8'h00;
                  cnt_d   = 12'd1;
               end
            end
         end
         PUT: begin
            if (pend_q) begin
               pend_d  = 1'b0;
               state_d = CLR_ROW;
               wren_d  = 1'b1;
               waddr_d = row_addr_q;
               wdata_d = 8'h00;
               cnt_d   = 12'd1;
            end else begin
               state_d = IDLE;
            end
         end
         CLR_ROW: begin
            // cnt_q is the next column to blank.
            if (cnt_q == 12'(COLS)) begin
               state_d = IDLE;
            end else begin
               wren_d  = 1'b1;
               waddr_d = row_addr_q + cnt_q;
               wdata_d = 8'h00;
               cnt_d   = cnt_q + 12'd1;
            end
         end
         CLR_ALL: begin
            if (cnt_q == 12'(CELLS)) begin
               state_d = IDLE;
            end else begin
               wren_d  = 1'b1;
               waddr_d = cnt_q;
               wdata_d = 8'h00;
               cnt_d   = cnt_q + 12'd1;
            end
         end
         default: state_d = CLR_ALL;
      endcase

      cur_d = row_start(wrap_row(base_d, ly_d)) + 12'(cx_d);
   end

   always_ff @(posedge CLOCK_50 or negedge clrn) begin
      if (!clrn) begin
         state_q    <= CLR_ALL;
         cx_q       <= 7'd0;
         ly_q       <= 5'd0;
         base_q     <= 5'd0;
         cnt_q      <= 12'd0;
         row_addr_q <= 12'd0;
         pend_q     <= 1'b0;
         wren_q     <= 1'b0;
         waddr_q    <= 12'd0;
         wdata_q    <= 8'h00;
         cur_q      <= 12'd0;
      end else begin
         state_q    <= state_d;
         cx_q       <= cx_d;
         ly_q       <= ly_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         row_addr_q <= row_addr_d;
         pend_q     <= pend_d;
         wren_q     <= wren_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         cur_q      <= cur_d;
      end
   end

   assign char_ready  = (state_q == IDLE);
   assign wren        = wren_q;
   assign wraddress   = waddr_q;
   assign wrdata      = wdata_q;
   assign scroll_base = base_q;
   assign cursor_addr = cur_q;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: logs every RAM write and checks addresses,
// data, cursor and scroll state against hand-computed values.
module tb_text_console;

   logic        clk = 1'b0;
   logic        clrn;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic [11:0] wraddress;
   logic [7:0]  wrdata;
   logic        wren;
   logic [4:0]  scroll_base;
   logic [11:0] cursor_addr;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [11:0] wa_q[$];
   logic [7:0]  wd_q[$];
   int          wc_q[$];

   text_console #(.COLS(70), .ROWS(30)) dut (
      .CLOCK_50    (clk),
      .clrn        (clrn),
      .char_valid  (char_valid),
      .char_data   (char_data),
      .char_ready  (char_ready),
      .wraddress   (wraddress),
      .wrdata      (wrdata),
      .wren        (wren),
      .scroll_base (scroll_base),
      .cursor_addr (cursor_addr)
   );

   always #5 clk = ~clk;

   // Write log: one entry per cycle with wren high, tagged with a cycle number.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (wren === 1'b1) begin
         wa_q.push_back(wraddress);
         wd_q.push_back(wrdata);
         wc_q.push_back(cyc);
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (char_ready !== 1'b1) begin
         tests++; fails++;
         $display("FAIL send_timeout byte=%h ready=%b required 1", b, char_ready);
      end
      char_valid = 1'b1;
      char_data  = b;
      @(negedge clk);
      char_valid = 1'b0;
      char_data  = 8'hxx;
   endtask

   task automatic wait_ready(input int budget);
      int n = 0;
      while (char_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (char_ready !== 1'b1) begin
         fails++;
         $display("FAIL wait_ready ready=%b required 1 after %0d cycles", char_ready, n);
      end
      @(negedge clk);
   endtask

   task automatic check_full_clear(input int s0, input string tag);
      int n;
      int bad;
      n = wa_q.size() - s0;
      tests++;
      if (n !== 2100) begin
         fails++;
         $display("FAIL %s_count writes=%0d required 2100", tag, n);
      end
      bad = 0;
      for (int i = 0; i < n && i < 2100; i++)
         if (wa_q[s0+i] !== 12'(i) || wd_q[s0+i] !== 8'h00) bad++;
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL %s_seq bad_entries=%0d required 0", tag, bad);
      end
   endtask

   task automatic test_reset();
      int s0;
      clrn = 1'b1; char_valid = 1'b0; char_data = 8'h00;
      #2 clrn = 1'b0;
      @(negedge clk);
      tests++;
      if (wren !== 1'b0 || char_ready !== 1'b0 || wraddress !== 12'd0 || wrdata !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs wren=%b ready=%b addr=%0d data=%h required 0 0 0 00",
                  wren, char_ready, wraddress, wrdata);
      end
      @(negedge clk);
      s0 = wa_q.size();
      clrn = 1'b1;
      wait_ready(3000);
      check_full_clear(s0, "reset_clear");
      tests++;
      if (scroll_base !== 5'd0 || cursor_addr !== 12'd0) begin
         fails++;
         $display("FAIL reset_state base=%0d cursor=%0d required 0 0", scroll_base, cursor_addr);
      end
   endtask

   task automatic test_print_bs();
      int s0 = wa_q.size();
      send(8'h41);
      tests++;
      if (char_ready !== 1'b0 || wren !== 1'b1 || wraddress !== 12'd0 || wrdata !== 8'h41) begin
         fails++;
         $display("FAIL put_cycle ready=%b wren=%b addr=%0d data=%h required 0 1 0 41",
                  char_ready, wren, wraddress, wrdata);
      end
      @(negedge clk);
      tests++;
      if (char_ready !== 1'b1 || wren !== 1'b0) begin
         fails++;
         $display("FAIL put_ready_back ready=%b wren=%b required 1 0", char_ready, wren);
      end
      send(8'h42);
      send(8'h08);
      wait_ready(10);
      tests++;
      if (wa_q.size() - s0 !== 3 ||
          wa_q[s0] !== 12'd0 || wd_q[s0] !== 8'h41 ||
          wa_q[s0+1] !== 12'd1 || wd_q[s0+1] !== 8'h42 ||
          wa_q[s0+2] !== 12'd1 || wd_q[s0+2] !== 8'h00) begin
         fails++;
         $display("FAIL print_bs_writes count=%0d required 3 (0,41)(1,42)(1,00)", wa_q.size() - s0);
      end
      tests++;
      if (cursor_addr !== 12'd1) begin
         fails++;
         $display("FAIL print_bs_cursor cursor=%0d required 1", cursor_addr);
      end
   endtask

   task automatic test_wrap();
      int s0;
      int bad = 0;
      send(8'h0D);
      s0 = wa_q.size();
      for (int i = 0; i < 70; i++) send(8'h78);
      wait_ready(10);
      tests++;
      if (wa_q.size() - s0 !== 70) begin
         fails++;
         $display("FAIL wrap_count writes=%0d required 70", wa_q.size() - s0);
      end else begin
         for (int i = 0; i < 70; i++)
            if (wa_q[s0+i] !== 12'(i) || wd_q[s0+i] !== 8'h78) bad++;
         if (bad !== 0) begin
            fails++;
            $display("FAIL wrap_seq bad_entries=%0d required 0 (last addr %0d required 69)",
                     bad, wa_q[s0+69]);
         end
      end
      tests++;
      if (cursor_addr !== 12'd70) begin
         fails++;
         $display("FAIL wrap_cursor cursor=%0d required 70", cursor_addr);
      end
   endtask

   task automatic test_scroll();
      int s0;
      int bad = 0;
      send(8'h0C);
      wait_ready(3000);
      s0 = wa_q.size();
      send(8'h0A);
      tests++;
      if (char_ready !== 1'b1 || wren !== 1'b0) begin
         fails++;
         $display("FAIL lf_no_scroll ready=%b wren=%b required 1 0", char_ready, wren);
      end
      for (int i = 0; i < 28; i++) send(8'h0A);
      send(8'h51);
      wait_ready(10);
      send(8'h0A);
      tests++;
      if (wren !== 1'b1 || wraddress !== 12'd0 || scroll_base !== 5'd1 || char_ready !== 1'b0) begin
         fails++;
         $display("FAIL scroll_start wren=%b addr=%0d base=%0d ready=%b required 1 0 1 0",
                  wren, wraddress, scroll_base, char_ready);
      end
      wait_ready(100);
      tests++;
      if (wa_q.size() - s0 !== 71 || wa_q[s0] !== 12'd2030 || wd_q[s0] !== 8'h51) begin
         fails++;
         $display("FAIL scroll_q writes=%0d first_addr=%0d first_data=%h required 71 2030 51",
                  wa_q.size() - s0, wa_q[s0], wd_q[s0]);
      end else begin
         for (int i = 0; i < 70; i++)
            if (wa_q[s0+1+i] !== 12'(i) || wd_q[s0+1+i] !== 8'h00) bad++;
         tests++;
         if (bad !== 0) begin
            fails++;
            $display("FAIL scroll_clear_row bad_entries=%0d required 0", bad);
         end
      end
      tests++;
      if (scroll_base !== 5'd1 || cursor_addr !== 12'd0) begin
         fails++;
         $display("FAIL scroll_state base=%0d cursor=%0d required 1 0", scroll_base, cursor_addr);
      end
      // Fill the bottom row: the 70th glyph triggers PUT then CLR_ROW of physical row 1.
      s0 = wa_q.size();
      bad = 0;
      for (int i = 0; i < 70; i++) send(8'h79);
      wait_ready(100);
      tests++;
      if (wa_q.size() - s0 !== 140) begin
         fails++;
         $display("FAIL wrap_scroll_count writes=%0d required 140", wa_q.size() - s0);
      end else begin
         for (int i = 0; i < 70; i++) begin
            if (wa_q[s0+i] !== 12'(i) || wd_q[s0+i] !== 8'h79) bad++;
            if (wa_q[s0+70+i] !== 12'(70 + i) || wd_q[s0+70+i] !== 8'h00) bad++;
         end
         if (wc_q[s0+70] !== wc_q[s0+69] + 1) bad++;
         if (bad !== 0) begin
            fails++;
            $display("FAIL wrap_scroll_seq bad_entries=%0d required 0", bad);
         end
      end
      tests++;
      if (scroll_base !== 5'd2 || cursor_addr !== 12'd70) begin
         fails++;
         $display("FAIL wrap_scroll_state base=%0d cursor=%0d required 2 70", scroll_base, cursor_addr);
      end
   endtask

   task automatic test_edge_codes();
      int s0 = wa_q.size();
      send(8'h0C);
      wait_ready(3000);
      check_full_clear(s0, "ff_clear");
      tests++;
      if (scroll_base !== 5'd0 || cursor_addr !== 12'd0) begin
         fails++;
         $display("FAIL ff_state base=%0d cursor=%0d required 0 0", scroll_base, cursor_addr);
      end
      s0 = wa_q.size();
      send(8'h08);
      tests++;
      if (char_ready !== 1'b1 || wren !== 1'b0) begin
         fails++;
         $display("FAIL bs_home ready=%b wren=%b required 1 0", char_ready, wren);
      end
      @(negedge clk);
      tests++;
      if (wa_q.size() !== s0 || cursor_addr !== 12'd0) begin
         fails++;
         $display("FAIL bs_home_nowrite writes=%0d cursor=%0d required 0 0", wa_q.size() - s0, cursor_addr);
      end
      for (int i = 0; i < 5; i++) send(8'h61);
      wait_ready(10);
      s0 = wa_q.size();
      send(8'h0D);
      tests++;
      if (char_ready !== 1'b1 || cursor_addr !== 12'd0) begin
         fails++;
         $display("FAIL cr ready=%b cursor=%0d required 1 0", char_ready, cursor_addr);
      end
      send(8'h07);
      tests++;
      if (char_ready !== 1'b1 || wren !== 1'b0 || cursor_addr !== 12'd0 || wa_q.size() !== s0) begin
         fails++;
         $display("FAIL bel_ignored ready=%b wren=%b cursor=%0d writes=%0d required 1 0 0 0",
                  char_ready, wren, cursor_addr, wa_q.size() - s0);
      end
      send(8'h0A);
      send(8'h08);
      wait_ready(10);
      tests++;
      if (wa_q.size() - s0 !== 1 || wa_q[s0] !== 12'd69 || wd_q[s0] !== 8'h00 || cursor_addr !== 12'd69) begin
         fails++;
         $display("FAIL bs_prev_row writes=%0d addr=%0d cursor=%0d required 1 69 69",
                  wa_q.size() - s0, wa_q[s0], cursor_addr);
      end
   endtask

   task automatic test_mid_reset();
      int s0;
      for (int i = 0; i < 30; i++) send(8'h0A);
      repeat (10) @(negedge clk);
      tests++;
      if (char_ready !== 1'b0 || wren !== 1'b1 || scroll_base !== 5'd1) begin
         fails++;
         $display("FAIL midrst_pre ready=%b wren=%b base=%0d required 0 1 1", char_ready, wren, scroll_base);
      end
      clrn = 1'b0;
      #1;
      tests++;
      if (wren !== 1'b0 || char_ready !== 1'b0 || wraddress !== 12'd0 || wrdata !== 8'h00 ||
          scroll_base !== 5'd0 || cursor_addr !== 12'd0) begin
         fails++;
         $display("FAIL midrst_outputs wren=%b ready=%b addr=%0d data=%h base=%0d cursor=%0d required 0 0 0 00 0 0",
                  wren, char_ready, wraddress, wrdata, scroll_base, cursor_addr);
      end
      @(negedge clk);
      @(negedge clk);
      s0 = wa_q.size();
      clrn = 1'b1;
      wait_ready(3000);
      check_full_clear(s0, "midrst_clear");
   endtask

   initial begin
      test_reset();
      test_print_bs();
      test_wrap();
      test_scroll();
      test_edge_codes();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/text_console.md
# text_console

Character-stream front end for the 70×30 text-mode display. It accepts one ASCII byte at a time over a valid/ready handshake and tracks a cursor. It writes glyph codes into the write port of the character RAM that the VGA text renderer reads, and handles newline, carriage return, backspace, form-feed clear and line-wrap. It scrolls by rotating a top-row base pointer, which the renderer adds to its row index modulo 30, and blanks the newly exposed row.

## Interface
- `COLS`, 70: characters per row.
- `ROWS`, 30: rows per screen.
- `CLOCK_50` in 1: system clock; all logic is on the rising edge.
- `clrn` in 1: asynchronous, active-low reset.
- `char_valid` in 1: the upstream source (CPU or keyboard) presents a byte.
- `char_data` in 8: the ASCII byte.
- `char_ready` out 1: the block can accept a byte this cycle.
- `wraddress` out 12: character RAM write address, equal to `phys_row*70 + col`, range 0..2099.
- `wrdata` out 8: character RAM write data.
- `wren` out 1: character RAM write enable, one cycle per write.
- `scroll_base` out 5: physical RAM row shown at the top of the screen, range 0..29.
- `cursor_addr` out 12: RAM address of the cursor cell, for cursor blink.

## Operation
- **State.**
  - `cx`: column, 0..69.
  - `ly`: logical row, 0..29.
  - `base` drives `scroll_base`.
  - Physical row is `pr = (base+ly)` wrapped at 30, computed with a compare-subtract, not a divider.
- **FSM states:**
  - IDLE: `char_ready`=1.
  - PUT: the single registered write cycle.
  - CLR_ROW: 70 sequential writes of 0x00.
  - CLR_ALL: 2100 sequential writes of 0x00 at addresses 0..2099.
  - `char_ready`=0 in every state except IDLE.
- **Accept rule.** A byte is accepted on a rising edge with `char_valid && char_ready`. Bytes are never dropped or duplicated. `char_data` is sampled only on the accept edge.
- **0x20..0x7E (printable).**
  - Go to PUT and write the byte at `(pr, cx)`.
  - If `cx`<69, then `cx`+1.
  - If `cx`==69, perform an advance.
- **0x0A (LF).** Set `cx`=0, then perform an advance. No write occurs unless a scroll follows.
- **0x0D (CR).** Set `cx`=0. No write occurs; stay in IDLE.
- **0x08 (BS).**
  - If `cx`>0, then `cx`-1 and write 0x00 at the new cell via PUT.
  - Else if `ly`>0, then `ly`-1, `cx`=69, and write 0x00 there.
  - Else no-op: no write, stay in IDLE.
- **0x0C (FF).** Go to CLR_ALL, then set `cx`=0, `ly`=0, `base`=0.
- **Any other code.** Accepted and discarded; no write, no cursor change.
- **Advance.**
  - If `ly`<29, then `ly`+1.
  - Else scroll:
    - `base` becomes `base+1`, wrapping 29→0.
    - `ly` stays 29.
    - Go to CLR_ROW for the new bottom physical row `(newbase+29)` wrapped at 30, which equals the old `base`.
    - CLR_ROW writes columns 0..69 of that row.
- **Printable at `cx`==69, `ly`==29.** The sequence is PUT, then CLR_ROW, then IDLE.
- **Reset.**
  - Enters CLR_ALL immediately, so the RAM is blanked after power-up.
  - `cx`=`ly`=`base`=0, `wren`=0, `wraddress`=0, `wrdata`=0, `char_ready`=0.
- **Reset mid-clear or mid-PUT.** Aborts at once and restarts CLR_ALL from address 0.

## Timing
- **Write latency.** A byte accepted at edge N is written with `wren`=1 during cycle N+1.
- **PUT.** Exactly 1 cycle. `char_ready` returns to 1 in cycle N+2, so peak throughput is one printable byte per 2 cycles.
- **Non-writing codes.** CR, LF without scroll, ignored codes and BS at home stay in IDLE, so `char_ready` stays 1 and the next byte can be accepted at edge N+1.
- **CLR_ROW.**
  - `wren`=1 for 70 consecutive cycles at addresses `r*70+0` .. `r*70+69`.
  - Entered directly after PUT with no idle gap, or directly after the LF accept.
  - `char_ready` returns to 1 on the cycle after the last write.
- **CLR_ALL.** `wren`=1 for 2100 consecutive cycles at addresses 0..2099, with `wrdata`=0.
- **Register timing.** `scroll_base` and `cursor_addr` are registered and update on the edge that leaves PUT, CLR_ROW or IDLE. `scroll_base` changes before CLR_ROW begins.
- **Between writes.** `wraddress` and `wrdata` hold their last values while `wren`=0.

## Test plan
- **Reset.** Release `clrn`. Required response:
  - 2100 writes of 0x00 at addresses 0..2099.
  - Then `char_ready`=1, `scroll_base`=0, `cursor_addr`=0.
- **Printable and backspace.** Send "AB", then 0x08. Required response:
  - Writes (0,0x41) and (1,0x42), then (1,0x00).
  - `cursor_addr`=1.
  - Each printable deasserts `char_ready` for exactly 1 cycle.
- **Line wrap.** Send 70× 'x' starting from home. Required response:
  - The last write is at address 69.
  - `cursor_addr`=70 (`ly`=1, `cx`=0).
- **Scroll.** Send 29× LF, then "Q", then LF. Required response:
  - 'Q' is written at address 2030.
  - The final LF sets `scroll_base`=1 and clears addresses 0..69 (70 writes).
  - `cursor_addr`=0.
- **Edge codes.**
  - BS at home produces no write and `char_ready` stays 1.
  - CR at `cx`=5 gives `cx`=0.
  - 0x07 is consumed with no effect.
  - FF after scrolling performs 2100 clears and sets `scroll_base`=0.
- **Mid-operation reset.** Assert `clrn` during CLR_ROW. Required response:
  - Outputs are at reset values in the same cycle.
  - After release, a full CLR_ALL runs from address 0.
